// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial "010" scan controller.
package seq_scan_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 5;

    typedef logic [1:0] ctrl_state_t;
    localparam ctrl_state_t IDLE  = 2'd0;
    localparam ctrl_state_t SHIFT = 2'd1;
    localparam ctrl_state_t DRAIN = 2'd2;
    localparam ctrl_state_t DONE  = 2'd3;

    typedef logic [1:0] det_state_t;
    localparam det_state_t S0 = 2'd0;
    localparam det_state_t S1 = 2'd1;
    localparam det_state_t S2 = 2'd2;
    localparam det_state_t S3 = 2'd3;

    // Wide enough for any legal CNT_W; users take the low CNT_W bits.
    localparam logic [31:0] POS_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Request/response bundle of the scan controller. first_pos exists only
// when MATCH_POS_EN is defined.
interface seq_scan_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  match_cnt;
`ifdef MATCH_POS_EN
    logic [CNT_W-1:0]  first_pos;

    modport master (output start, data, len, input busy, done, match_cnt, first_pos);
    modport slave  (input start, data, len, output busy, done, match_cnt, first_pos);
`else
    modport master (output start, data, len, input busy, done, match_cnt);
    modport slave  (input start, data, len, output busy, done, match_cnt);
`endif
endinterface

// File: rtl/bit_pattern_det.sv
// Moore detector for overlapping "010" on a serial bit stream; hit = S3.
//   state | meaning
//   S0    | nothing useful seen
//   S1    | last bit 0
//   S2    | last bits 01
//   S3    | last bits 010 (match)
module bit_pattern_det
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in,
    output logic hit
);

    det_state_t state, state_nx;

    always_comb begin
        state_nx = S0;
        case (state)
            S0: state_nx = in ? S0 : S1;
            S1: state_nx = in ? S2 : S1;
            S2: state_nx = in ? S0 : S3;
            S3: state_nx = in ? S2 : S1;
            default: state_nx = S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S0;
        else if (clr)
            state <= S0;
        else
            state <= state_nx;
    end

    assign hit = (state == S3);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level scan controller around bit_pattern_det. Optional first-match
// position output is enabled with MATCH_POS_EN.
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | feeding shift_reg MSB-first into the detector
//   DRAIN | last fed bit's hit becomes visible
//   DONE  | result valid, done pulse
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    seq_scan_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONES = POS_NONE[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(DATA_W);

    ctrl_state_t       state;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  match_cnt_q;
    logic [CNT_W-1:0]  eff_len;
    logic              accept;
    logic              counting;
    logic              det_hit;

    assign eff_len  = (bus.len == '0 || bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    assign accept   = (state == IDLE) && bus.start;
    assign counting = (state == SHIFT) || (state == DRAIN);

    bit_pattern_det u_det (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .in  (shift_reg[DATA_W-1]),
        .hit (det_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            len_q     <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg <= bus.data;
                        len_q     <= eff_len;
                        bit_idx   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                    bit_idx   <= bit_idx + CNT_W'(1);
                    if (bit_idx == len_q - CNT_W'(1))
                        state <= DRAIN;
                end
                DRAIN:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            match_cnt_q <= '0;
        else if (accept)
            match_cnt_q <= '0;
        else if (counting && det_hit && match_cnt_q != CNT_ONES)
            match_cnt_q <= match_cnt_q + CNT_W'(1);
    end

`ifdef MATCH_POS_EN
    logic [CNT_W-1:0] first_pos_q;

    // A visible hit belongs to the bit fed one cycle earlier, i.e. bit_idx-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            first_pos_q <= CNT_ONES;
        else if (accept)
            first_pos_q <= CNT_ONES;
        else if (counting && det_hit && first_pos_q == CNT_ONES)
            first_pos_q <= bit_idx - CNT_W'(1);
    end

    assign bus.first_pos = first_pos_q;
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.match_cnt = match_cnt_q;

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Scan controller that sequences a serial "010" pattern detector over a parallel data word. On `start` it captures a DATA_W-bit word and a bit count, feeds the word MSB-first into the detector one bit per cycle, and counts overlapping matches. It then reports the count with a one-cycle `done` pulse. It sits between a register-mapped command source and the bit-serial detector, turning one-bit-per-cycle detection into a word-level request/response operation.

## Interface
Parameters:
- DATA_W, 16, width of the scanned word.
- CNT_W, 5, width of bit counter and result fields; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- data  in  DATA_W  word to scan, captured on accepted start.
- len  in  CNT_W  number of bits to scan, taken from the MSB down; 0 or values >DATA_W mean DATA_W.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse when the result is valid.
- match_cnt  out  CNT_W  overlapping "010" matches in the last scan.
- first_pos  out  CNT_W  present only with MATCH_POS_EN (see Configuration).

## Operation
- Reset (rst=0, asynchronous):
  - controller goes to IDLE and detector to S0;
  - busy=0, done=0, match_cnt=0, first_pos=all-ones.
  - Reset mid-scan abandons the scan; no done pulse is produced.
- Detector states (Moore), `hit` = (state==S3):
  - S0: in=0→S1, else S0
  - S1: in=0→S1, else S2
  - S2: in=0→S3, else S0
  - S3: in=0→S1, else S2
  - Synchronous `clr` forces S0.
- Controller states:
  - IDLE: start=1 → capture data into shift register, capture effective len L, clear bit index, clear match_cnt, assert detector clr; next SHIFT.
  - SHIFT: drive detector with shift_reg[MSB], shift left, increment index. After the cycle feeding bit L-1, go to DRAIN.
  - DRAIN: one cycle so the final bit's hit becomes visible; next DONE.
  - DONE: done=1 for this cycle only; next IDLE.
- Counting:
  - In every SHIFT and DRAIN cycle, hit=1 increments match_cnt.
  - match_cnt saturates at all-ones (unreachable for legal params, but required).
  - match_cnt holds its value from DONE until the next accepted start.
- start asserted in SHIFT/DRAIN/DONE is ignored and is not queued.

## Timing
- The start edge E0 enters SHIFT. SHIFT lasts L cycles, then DRAIN 1 cycle, then DONE 1 cycle.
- done is high during cycle L+2 after E0; busy drops in the cycle after done.
- The earliest next accepted start is the first IDLE cycle, giving back-to-back throughput of one scan per L+3 cycles.
- A hit is visible one cycle after the edge sampling the completing '0'.

## Configuration
- MATCH_POS_EN defined:
  - adds output `first_pos` (CNT_W): 0-based index, in feed order, of the bit that completed the first match in the scan;
  - all-ones if the scan has no match;
  - resets to all-ones and is set to all-ones on each accepted start.
- MATCH_POS_EN undefined: port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `seq_scan_pkg`: controller state typedef (IDLE, SHIFT, DRAIN, DONE), detector state typedef (S0–S3), and the all-ones sentinel constant for first_pos.
- Sub-module `bit_pattern_det` (clk, rst, clr, in, hit) holds the detector FSM. The controller owns the shift register, bit index, counters and handshake.

## Test plan
- data=16'h5000 (0101 then zeros), len=0 → done at E0+18, match_cnt=2, first_pos=2.
- data=16'h5555, len=16 → match_cnt=7, first_pos=2; data=16'hFFFF → match_cnt=0, first_pos=5'h1F; data=16'h0000 → match_cnt=0.
- data=16'h4000, len=3 → busy for 5 cycles, done during cycle 5 after E0, match_cnt=1, first_pos=2.
- Start held high through a 16'h5555 scan → exactly one done pulse; the re-sampled start in IDLE begins a second scan with identical result 7.
- rst pulsed low mid-SHIFT of 16'h5555 → busy=0, done=0, match_cnt=0 immediately, no done pulse; a following start with 16'h5555 → 7.
- Back-to-back scans 16'h5555 then 16'h0000 → second result 0, proving match_cnt and the detector clear on each start.
